// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the FSM encoding and the word-address helper.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      LD_IDLE  = 3'd0,
      LD_HDR0  = 3'd1,
      LD_HDR1  = 3'd2,
      LD_DATA  = 3'd3,
      LD_CSUM  = 3'd4,
      LD_DONE  = 3'd5,
      LD_ERROR = 3'd6
   } ld_state_e;

   localparam int LANES  = 4;
   localparam int LANE_W = $clog2(LANES);

   function automatic logic [31:0] word_addr(
      input logic [31:0] base,
      input logic [31:0] idx
   );
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready link feeding the loader.
// master = byte source, slave = loader.
interface imem_loader_if;

   logic       BYTE_VALID;
   logic       BYTE_READY;
   logic [7:0] BYTE_DATA;

   modport master (
      output BYTE_VALID,
      output BYTE_DATA,
      input  BYTE_READY
   );

   modport slave (
      input  BYTE_VALID,
      input  BYTE_DATA,
      output BYTE_READY
   );

endinterface

// File: rtl/imem_loader_word_asm.sv
// Byte-lane assembler: packs payload bytes LSB first into words
// and keeps the modulo-256 payload checksum.
module imem_loader_word_asm
   import imem_loader_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        clr_i,
   input  logic        acc_i,
   input  logic [7:0]  byte_i,
   output logic        word_rdy_o,
   output logic [31:0] word_o,
   output logic [7:0]  csum_o
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [23:0]       sh_q, sh_d;
   logic [7:0]        csum_q, csum_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lane_q <= '0;
         sh_q   <= '0;
         csum_q <= '0;
      end else begin
         lane_q <= lane_d;
         sh_q   <= sh_d;
         csum_q <= csum_d;
      end
   end

   // Older bytes slide toward bit 0 so lane 0 ends up as the LSB.
   always_comb begin
      lane_d = lane_q;
      sh_d   = sh_q;
      csum_d = csum_q;
      if (clr_i) begin
         lane_d = '0;
         sh_d   = '0;
         csum_d = '0;
      end else if (acc_i) begin
         lane_d = lane_q + 1'b1;
         sh_d   = {byte_i, sh_q[23:8]};
         csum_d = csum_q + byte_i;
      end
   end

   assign word_rdy_o = acc_i && !clr_i
                       && (lane_q == LANE_W'(LANES - 1));
   assign word_o     = {byte_i, sh_q};
   assign csum_o     = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted byte stream, writes imem one word
// at a time and releases the CPU only after the checksum matches.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                START,
   imem_loader_if.slave        bs,
   output logic                IMEM_WE,
   output logic [31:0]         IMEM_WADDR,
   output logic [31:0]         IMEM_WDATA,
   output logic                CPU_RST,
   output logic                BUSY,
   output logic                DONE,
   output logic                ERR
);

   ld_state_e         state_q, state_d;
   logic [7:0]        n_lo_q, n_lo_d;
   logic [ADDR_W:0]   n_q, n_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic              we_q, we_d;
   logic [31:0]       waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic              rdy;
   logic              acc;
   logic              clr;
   logic              word_rdy;
   logic [31:0]       word;
   logic [7:0]        csum;
   logic [16:0]       n_full;
   logic              n_ok;
   logic [ADDR_W:0]   idx_nxt;

   assign rdy = (state_q == LD_HDR0) || (state_q == LD_HDR1)
             || (state_q == LD_DATA) || (state_q == LD_CSUM);
   assign acc = bs.BYTE_VALID && rdy;

   assign n_full  = {1'b0, bs.BYTE_DATA, n_lo_q};
   assign n_ok    = (n_full != 17'd0)
                 && (n_full <= (17'd1 << ADDR_W));
   assign idx_nxt = idx_q + 1'b1;

   imem_loader_word_asm u_asm (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .clr_i      (clr),
      .acc_i      (acc && (state_q == LD_DATA)),
      .byte_i     (bs.BYTE_DATA),
      .word_rdy_o (word_rdy),
      .word_o     (word),
      .csum_o     (csum)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= LD_IDLE;
         n_lo_q  <= '0;
         n_q     <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= BASE_ADDR;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         n_lo_q  <= n_lo_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_lo_d  = n_lo_q;
      n_d     = n_q;
      idx_d   = idx_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      clr     = 1'b0;
      unique case (state_q)
         LD_IDLE, LD_DONE, LD_ERROR: begin
            if (START) begin
               state_d = LD_HDR0;
               idx_d   = '0;
               n_d     = '0;
               clr     = 1'b1;
            end
         end
         LD_HDR0: begin
            if (acc) begin
               n_lo_d  = bs.BYTE_DATA;
               state_d = LD_HDR1;
            end
         end
         LD_HDR1: begin
            if (acc) begin
               n_d     = n_full[ADDR_W:0];
               state_d = n_ok ? LD_DATA : LD_ERROR;
            end
         end
         LD_DATA: begin
            if (word_rdy) begin
               we_d    = 1'b1;
               wdata_d = word;
               waddr_d = word_addr(BASE_ADDR, 32'(idx_q));
               idx_d   = idx_nxt;
               if (idx_nxt == n_q) state_d = LD_CSUM;
            end
         end
         LD_CSUM: begin
            if (acc) begin
               state_d = (bs.BYTE_DATA == csum) ? LD_DONE
                                                 : LD_ERROR;
            end
         end
         default: state_d = LD_IDLE;
      endcase
   end

   assign bs.BYTE_READY = rdy;
   assign IMEM_WE       = we_q;
   assign IMEM_WADDR    = waddr_q;
   assign IMEM_WDATA    = wdata_q;
   assign BUSY          = rdy;
   assign DONE          = (state_q == LD_DONE);
   assign ERR           = (state_q == LD_ERROR);
   assign CPU_RST       = (state_q != LD_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (base 0, base 0x100)
// share one stimulus stream; a monitor pops expected writes.
module tb_imem_loader;

   localparam int          AW = 10;
   localparam logic [31:0] B0 = 32'h0000_0000;
   localparam logic [31:0] B1 = 32'h0000_0100;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        valid;
   logic [7:0]  data;

   logic        we0, we1;
   logic [31:0] waddr0, waddr1, wdata0, wdata1;
   logic        cpu0, cpu1, busy0, busy1, done0, done1, err0, err1;

   int          vectors = 0;
   int          miscompares = 0;
   wr_t         exp0[$];
   wr_t         exp1[$];
   wr_t         e0, e1;
   logic [31:0] last1;

   always #5 clk = ~clk;

   imem_loader_if bif0 ();
   imem_loader_if bif1 ();

   assign bif0.BYTE_VALID = valid;
   assign bif0.BYTE_DATA  = data;
   assign bif1.BYTE_VALID = valid;
   assign bif1.BYTE_DATA  = data;

   imem_loader #(.ADDR_W(AW), .BASE_ADDR(B0)) dut0 (
      .CLK(clk), .RST_N(rst_n), .START(start), .bs(bif0.slave),
      .IMEM_WE(we0), .IMEM_WADDR(waddr0), .IMEM_WDATA(wdata0),
      .CPU_RST(cpu0), .BUSY(busy0), .DONE(done0), .ERR(err0)
   );

   imem_loader #(.ADDR_W(AW), .BASE_ADDR(B1)) dut1 (
      .CLK(clk), .RST_N(rst_n), .START(start), .bs(bif1.slave),
      .IMEM_WE(we1), .IMEM_WADDR(waddr1), .IMEM_WDATA(wdata1),
      .CPU_RST(cpu1), .BUSY(busy1), .DONE(done1), .ERR(err1)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, want);
      end
   endtask

   task automatic chk_status(input string nm, input bit dn,
                             input bit er, input bit cr, input bit bz);
      chk({nm, " DONE0"}, {31'b0, done0}, {31'b0, dn});
      chk({nm, " ERR0"},  {31'b0, err0},  {31'b0, er});
      chk({nm, " CPU0"},  {31'b0, cpu0},  {31'b0, cr});
      chk({nm, " BUSY0"}, {31'b0, busy0}, {31'b0, bz});
      chk({nm, " DONE1"}, {31'b0, done1}, {31'b0, dn});
      chk({nm, " ERR1"},  {31'b0, err1},  {31'b0, er});
      chk({nm, " CPU1"},  {31'b0, cpu1},  {31'b0, cr});
      chk({nm, " BUSY1"}, {31'b0, busy1}, {31'b0, bz});
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (we0 === 1'b1) begin
         if (exp0.size() == 0) begin
            chk("dut0 unexpected write", {31'b0, we0}, 32'd0);
         end else begin
            e0 = exp0.pop_front();
            chk("dut0 waddr", waddr0, e0.a);
            chk("dut0 wdata", wdata0, e0.d);
         end
      end
      if (we1 === 1'b1) begin
         last1 = waddr1;
         if (exp1.size() == 0) begin
            chk("dut1 unexpected write", {31'b0, we1}, 32'd0);
         end else begin
            e1 = exp1.pop_front();
            chk("dut1 waddr", waddr1, e1.a);
            chk("dut1 wdata", wdata1, e1.d);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap,
                            input bit ps);
      int t;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         valid = 1'b0;
         start = ps && (g == 0);
      end
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (bif0.BYTE_READY !== 1'b1 && t < 50) begin
         valid = 1'b0;
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("ready timeout", {31'b0, bif0.BYTE_READY}, 32'd1);
      valid = 1'b1;
      data  = b;
      @(posedge clk);
   endtask

   // Reference: header, LSB-first payload, byte-sum trailer.
   task automatic run_load(input int n, input logic [31:0] w[$],
                           input bit bad, input int gap,
                           input bit do_start, input bit mid_start,
                           input int stop_after);
      logic [15:0] nn;
      logic [7:0]  sum, b, cs;
      int          cnt;
      bit          ok;
      nn  = n[15:0];
      ok  = (n >= 1) && (n <= (1 << AW));
      sum = 8'd0;
      cnt = 0;
      if (do_start) begin
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk_status("started", 0, 0, 1, 1);
      end
      send_byte(nn[7:0], gap, 1'b0);
      send_byte(nn[15:8], gap, 1'b0);
      if (!ok) begin
         #1;
         chk_status("bad header", 0, 1, 1, 0);
         chk("bad header ready", {31'b0, bif0.BYTE_READY}, 32'd0);
         @(negedge clk);
         valid = 1'b0;
         return;
      end
      for (int i = 0; i < n; i++) begin
         for (int l = 0; l < 4; l++) begin
            b = w[i][8*l +: 8];
            if (stop_after >= 0 && cnt == stop_after) begin
               @(negedge clk);
               valid = 1'b0;
               return;
            end
            if (l == 3) begin
               exp0.push_back('{a: B0 + 32'(4 * i), d: w[i]});
               exp1.push_back('{a: B1 + 32'(4 * i), d: w[i]});
            end
            send_byte(b, gap, mid_start && cnt == 2 && gap > 0);
            sum = sum + b;
            cnt++;
         end
      end
      #1;
      chk("pre csum BUSY", {31'b0, busy0}, 32'd1);
      chk("pre csum CPU_RST", {31'b0, cpu0}, 32'd1);
      cs = bad ? sum + 8'd1 : sum;
      send_byte(cs, gap, 1'b0);
      #1;
      if (bad) chk_status("csum bad", 0, 1, 1, 0);
      else     chk_status("csum ok", 1, 0, 0, 0);
      chk("dut0 writes pending", exp0.size(), 32'd0);
      chk("dut1 writes pending", exp1.size(), 32'd0);
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk_status(nm, 0, 0, 1, 0);
      chk({nm, " READY0"}, {31'b0, bif0.BYTE_READY}, 32'd0);
      chk({nm, " READY1"}, {31'b0, bif1.BYTE_READY}, 32'd0);
      chk({nm, " WE0"}, {31'b0, we0}, 32'd0);
      chk({nm, " WE1"}, {31'b0, we1}, 32'd0);
      chk({nm, " WADDR0"}, waddr0, B0);
      chk({nm, " WADDR1"}, waddr1, B1);
      chk({nm, " WDATA0"}, wdata0, 32'd0);
      chk({nm, " WDATA1"}, wdata1, 32'd0);
   endtask

   initial begin
      logic [31:0] w[$];
      logic [31:0] none[$];
      int          n;
      rst_n = 1'b0;
      start = 1'b0;
      valid = 1'b0;
      data  = 8'd0;
      last1 = 32'd0;
      #13;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      w = '{32'h2000_0013, 32'h2401_002A};
      run_load(2, w, 1'b0, 0, 1'b1, 1'b0, -1);
      run_load(2, w, 1'b1, 0, 1'b1, 1'b0, -1);

      run_load(0, none, 1'b0, 0, 1'b1, 1'b0, -1);
      run_load(1025, none, 1'b0, 0, 1'b1, 1'b0, -1);
      run_load(16'hFFFF, none, 1'b0, 1, 1'b1, 1'b0, -1);

      w = '{$urandom()};
      run_load(1, w, 1'b0, 2, 1'b1, 1'b1, -1);

      w = '{$urandom(), $urandom()};
      run_load(2, w, 1'b0, 0, 1'b1, 1'b0, 5);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid-load reset");
      chk("reset writes pending", exp0.size(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      w = '{$urandom()};
      run_load(1, w, 1'b0, 0, 1'b1, 1'b0, -1);

      for (int k = 0; k < 6; k++) begin
         n = $urandom_range(1, 6);
         w = {};
         for (int i = 0; i < n; i++) w.push_back($urandom());
         run_load(n, w, ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 2), 1'b1, 1'b0, -1);
      end

      w = '{$urandom(), $urandom(), $urandom()};
      run_load(3, w, 1'b0, 0, 1'b1, 1'b0, -1);
      @(negedge clk);
      chk("reload pre CPU_RST", {31'b0, cpu0}, 32'd0);
      start = 1'b1;
      @(posedge clk);
      #1;
      chk_status("reload", 0, 0, 1, 1);
      @(negedge clk);
      start = 1'b0;
      w = {};
      for (int i = 0; i < 1024; i++) w.push_back($urandom());
      run_load(1024, w, 1'b0, 0, 1'b0, 1'b0, -1);
      chk("full load last addr", last1, 32'h0000_10FC);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU instruction memory. The CPU core is the only reader of that memory.
- Receives a byte stream over a valid/ready handshake (host link or UART receiver), assembles little-endian 32-bit words and drives a one-word write port into imem.
- Holds the CPU in reset until a complete, checksum-verified program has been written.

Parameters:
- ADDR_W, 10, number of word-address bits of imem; maximum program length is 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.

Ports:
- CLK, input, 1, system clock; all state changes on the rising edge.
- RST_N, input, 1, asynchronous, active-low reset.
- START, input, 1, single-cycle request to begin a load.
- BYTE_VALID, input, 1, BYTE_DATA is valid this cycle.
- BYTE_DATA, input, 8, stream byte.
- BYTE_READY, output, 1, the loader accepts a byte this cycle.
- IMEM_WE, output, 1, one-cycle write strobe to imem.
- IMEM_WADDR, output, 32, byte address of the word being written.
- IMEM_WDATA, output, 32, assembled instruction word.
- CPU_RST, output, 1, active-high reset to the CPU core (drives the core's RST).
- BUSY, output, 1, a load is in progress.
- DONE, output, 1, the last load succeeded; level signal.
- ERR, output, 1, the last load failed; level signal.

Behaviour:
- Reset (RST_N = 0, asynchronous):
  - FSM goes to IDLE.
  - CPU_RST = 1.
  - BYTE_READY, IMEM_WE, BUSY, DONE and ERR = 0.
  - IMEM_WADDR = BASE_ADDR, IMEM_WDATA = 0.
  - All counters and the checksum clear.
- Byte transfer: a byte is accepted on a rising edge where BYTE_VALID and BYTE_READY are both 1.
  - BYTE_READY = 1 exactly in states HDR0, HDR1, DATA and CSUM, and does not depend on BYTE_VALID.
- Stream format, in order:
  - N_lo, N_hi: 16-bit word count, little-endian.
  - 4*N payload bytes: each word is sent LSB first.
  - CSUM: 8-bit modulo-256 sum of all payload bytes. Header bytes are excluded from the sum.
- FSM states: IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERROR.
- Transitions:
  - IDLE, DONE or ERROR plus START → HDR0.
    - CPU_RST = 1 and BUSY = 1.
    - DONE and ERR clear.
    - Word index, byte lane and checksum clear.
  - HDR0 plus accepted byte → HDR1 (latches N_lo).
  - HDR1 plus accepted byte → DATA if 1 <= N <= 2^ADDR_W; otherwise → ERROR, with no writes issued.
  - DATA: each accepted byte goes into lane 0..3 and is added to the checksum.
    - On acceptance of lane 3: IMEM_WE = 1 for exactly the following cycle, with IMEM_WDATA = {b3,b2,b1,b0} and IMEM_WADDR = BASE_ADDR + 4*word_idx.
    - word_idx then increments.
    - After word N-1 is written → CSUM.
  - CSUM plus accepted byte: if it matches the running sum → DONE; otherwise → ERROR.
  - DONE: CPU_RST = 0, DONE = 1, BUSY = 0.
  - ERROR: ERR = 1, BUSY = 0, CPU_RST stays 1.
- Write latency: IMEM_WE is registered and pulses 1 cycle after the handshake of the lane-3 byte.
  - IMEM_WADDR and IMEM_WDATA are stable while IMEM_WE = 1 and hold their values afterwards.
- Back-to-back bytes at 1 per cycle are supported with no stalls. Gaps in BYTE_VALID of any length are tolerated.
- START while BUSY = 1 is ignored.
- START in DONE reasserts CPU_RST in the next cycle. This is how a reload is done.
- RST_N asserted mid-load aborts the load: the FSM returns to IDLE with CPU_RST = 1. Words already written stay in imem. There is no timeout.
- Width rules:
  - word_idx is ADDR_W+1 bits wide, so that it can represent 2^ADDR_W.
  - The address add is 32 bits and wraps modulo 2^32. This cannot occur for legal N with an aligned BASE_ADDR.

Decomposition:
- Shared package/header (loader_defs.vh, alongside alu_defs.vh): FSM state encodings (LD_IDLE..LD_ERROR, 3 bits).
- One sub-module is natural: ld_word_asm, which takes the byte lane counter, the 4-byte shift/assemble register and the checksum accumulator, and outputs word_ready and csum.
- The FSM and the address counter remain in imem_loader.

Test Plan:
- Basic load, 2 words at BASE_ADDR 0:
  - Stimulus: START, then bytes 02 00 | 13 00 00 20 | 2A 00 01 24 | CSUM = 0x82.
  - Required: writes (0x0, 0x2000_0013), then (0x4, 0x2401_002A); DONE = 1; CPU_RST falls 1 cycle after the CSUM handshake; ERR = 0.
- Checksum mismatch:
  - Stimulus: same stream with CSUM = 0x83.
  - Required: both writes still occur; ERR = 1; DONE = 0; CPU_RST stays 1.
- Bad header:
  - Stimulus: N = 0, then separately N = 2^ADDR_W + 1 (0x0401 at ADDR_W = 10).
  - Required: ERROR right after HDR1; IMEM_WE never asserts.
- Gapped valid:
  - Stimulus: 1-word load with BYTE_VALID high one cycle in every three; also START pulsed mid-DATA.
  - Required: same write as the no-gap case; START is ignored.
- Reset mid-load:
  - Stimulus: RST_N low after 5 payload bytes, then release and send a fresh 1-word load.
  - Required: immediately after RST_N falls, all outputs are at reset values; after release, the first write is to BASE_ADDR; DONE = 1.
- Reload from DONE and full-size load:
  - Stimulus: START in DONE; then a load with N = 1024 and BASE_ADDR = 0x100.
  - Required: CPU_RST returns to 1 on the next cycle; the last write goes to address 0x10FC; DONE = 1.
